// File: rtl/alu_rs_if.sv
// Dispatch, CDB and ALU-issue bundle for the ALU reservation station.
// master = dispatch/CDB/ALU side, slave = alu_rs.
interface alu_rs_if #(
  parameter int IQ_ADDR_W = 4
);
  logic                 rdy;
  logic                 update_stat;
  logic                 clear_flag_in;

  logic                 dsp_enable_in;
  logic [3:0]           dsp_calc_code_in;
  logic                 dsp_lhs_ready_in;
  logic [31:0]          dsp_lhs_in;
  logic                 dsp_rhs_ready_in;
  logic [31:0]          dsp_rhs_in;
  logic [IQ_ADDR_W-1:0] dsp_pos_in_iq_in;
  logic                 full_out;

  logic                 cdb_enable_in;
  logic [IQ_ADDR_W-1:0] cdb_pos_in_iq_in;
  logic [31:0]          cdb_result_in;

  logic                 alu_full_in;
  logic                 alu_calc_enable_out;
  logic [3:0]           alu_calc_code_out;
  logic [31:0]          alu_lhs_out;
  logic [31:0]          alu_rhs_out;
  logic [IQ_ADDR_W-1:0] alu_pos_in_iq_out;

  // Handshake: dispatch is accepted on an update edge only while full_out=0;
  // an issue is offered for exactly one cycle (alu_calc_enable_out=1) and
  // only when alu_full_in was 0 at the issue edge.
  modport master (
    output rdy, update_stat, clear_flag_in,
    output dsp_enable_in, dsp_calc_code_in, dsp_lhs_ready_in, dsp_lhs_in,
    output dsp_rhs_ready_in, dsp_rhs_in, dsp_pos_in_iq_in,
    output cdb_enable_in, cdb_pos_in_iq_in, cdb_result_in, alu_full_in,
    input  full_out, alu_calc_enable_out, alu_calc_code_out,
    input  alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
  );

  modport slave (
    input  rdy, update_stat, clear_flag_in,
    input  dsp_enable_in, dsp_calc_code_in, dsp_lhs_ready_in, dsp_lhs_in,
    input  dsp_rhs_ready_in, dsp_rhs_in, dsp_pos_in_iq_in,
    input  cdb_enable_in, cdb_pos_in_iq_in, cdb_result_in, alu_full_in,
    output full_out, alu_calc_enable_out, alu_calc_code_out,
    output alu_lhs_out, alu_rhs_out, alu_pos_in_iq_out
  );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU with CDB operand wakeup.
// Optional RS_OLDEST_FIRST_EN: issue the oldest ready entry instead of the lowest index.
module alu_rs #(
  parameter int RS_SIZE   = 8,
  parameter int IQ_ADDR_W = 4
) (
  input  logic    clk,
  input  logic    rst,
  alu_rs_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   valid_q;
  logic [RS_SIZE-1:0]   lhs_rdy_q;
  logic [RS_SIZE-1:0]   rhs_rdy_q;
  logic [3:0]           code_q [RS_SIZE];
  logic [31:0]          lhs_q  [RS_SIZE];
  logic [31:0]          rhs_q  [RS_SIZE];
  logic [IQ_ADDR_W-1:0] pos_q  [RS_SIZE];
`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0]     age_q  [RS_SIZE];
  logic [IDX_W-1:0]     best_age;
`endif

  logic                 calc_en_q;
  logic [3:0]           calc_code_q;
  logic [31:0]          calc_lhs_q;
  logic [31:0]          calc_rhs_q;
  logic [IQ_ADDR_W-1:0] calc_pos_q;

  logic                 full;
  logic [RS_SIZE-1:0]   ready_vec;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_found;
  logic                 dsp_lhs_hit;
  logic                 dsp_rhs_hit;

  assign full      = &valid_q;
  assign ready_vec = valid_q & lhs_rdy_q & rhs_rdy_q;

  // A tagged operand dispatched alongside its own broadcast is captured now,
  // otherwise it would wait forever for a result that has already gone by.
  assign dsp_lhs_hit = bus.cdb_enable_in && !bus.dsp_lhs_ready_in &&
                       (bus.dsp_lhs_in[IQ_ADDR_W-1:0] == bus.cdb_pos_in_iq_in);
  assign dsp_rhs_hit = bus.cdb_enable_in && !bus.dsp_rhs_ready_in &&
                       (bus.dsp_rhs_in[IQ_ADDR_W-1:0] == bus.cdb_pos_in_iq_in);

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
    best_age  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_vec[i] && (!sel_found || age_q[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q     <= '0;
      lhs_rdy_q   <= '0;
      rhs_rdy_q   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        code_q[i] <= '0;
        lhs_q[i]  <= '0;
        rhs_q[i]  <= '0;
        pos_q[i]  <= '0;
`ifdef RS_OLDEST_FIRST_EN
        age_q[i]  <= '0;
`endif
      end
      calc_en_q   <= 1'b0;
      calc_code_q <= '0;
      calc_lhs_q  <= '0;
      calc_rhs_q  <= '0;
      calc_pos_q  <= '0;
    end else if (bus.rdy) begin
      if (bus.clear_flag_in) begin
        valid_q   <= '0;
        calc_en_q <= 1'b0;
      end else if (bus.update_stat) begin
        calc_en_q <= 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
          if (valid_q[i] && bus.cdb_enable_in) begin
            if (!lhs_rdy_q[i] && lhs_q[i][IQ_ADDR_W-1:0] == bus.cdb_pos_in_iq_in) begin
              lhs_q[i]     <= bus.cdb_result_in;
              lhs_rdy_q[i] <= 1'b1;
            end
            if (!rhs_rdy_q[i] && rhs_q[i][IQ_ADDR_W-1:0] == bus.cdb_pos_in_iq_in) begin
              rhs_q[i]     <= bus.cdb_result_in;
              rhs_rdy_q[i] <= 1'b1;
            end
          end
        end
        if (bus.dsp_enable_in && !full) begin
`ifdef RS_OLDEST_FIRST_EN
          for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && age_q[i] != IDX_W'(RS_SIZE - 1))
              age_q[i] <= age_q[i] + 1'b1;
          end
          age_q[free_idx] <= '0;
`endif
          valid_q[free_idx]   <= 1'b1;
          code_q[free_idx]    <= bus.dsp_calc_code_in;
          lhs_rdy_q[free_idx] <= bus.dsp_lhs_ready_in | dsp_lhs_hit;
          lhs_q[free_idx]     <= dsp_lhs_hit ? bus.cdb_result_in : bus.dsp_lhs_in;
          rhs_rdy_q[free_idx] <= bus.dsp_rhs_ready_in | dsp_rhs_hit;
          rhs_q[free_idx]     <= dsp_rhs_hit ? bus.cdb_result_in : bus.dsp_rhs_in;
          pos_q[free_idx]     <= bus.dsp_pos_in_iq_in;
        end
      end else begin
        if (!bus.alu_full_in && sel_found) begin
          calc_en_q         <= 1'b1;
          calc_code_q       <= code_q[sel_idx];
          calc_lhs_q        <= lhs_q[sel_idx];
          calc_rhs_q        <= rhs_q[sel_idx];
          calc_pos_q        <= pos_q[sel_idx];
          valid_q[sel_idx]  <= 1'b0;
        end else begin
          calc_en_q <= 1'b0;
        end
      end
    end
  end

  assign bus.full_out            = full;
  assign bus.alu_calc_enable_out = calc_en_q;
  assign bus.alu_calc_code_out   = calc_code_q;
  assign bus.alu_lhs_out         = calc_lhs_q;
  assign bus.alu_rhs_out         = calc_rhs_q;
  assign bus.alu_pos_in_iq_out   = calc_pos_q;
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios with literal expectations,
// then randomized traffic checked against an entry-list model every cycle.
module tb_alu_rs;
  localparam int RS_SIZE   = 8;
  localparam int IQ_ADDR_W = 4;
  localparam int W         = 4 + 32 + 32 + IQ_ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_rs_if #(.IQ_ADDR_W(IQ_ADDR_W)) bus ();

  alu_rs #(.RS_SIZE(RS_SIZE), .IQ_ADDR_W(IQ_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        v;
    bit [3:0]  code;
    bit        lr;
    bit [31:0] lval;
    bit [3:0]  ltag;
    bit        rr;
    bit [31:0] rval;
    bit [3:0]  rtag;
    bit [3:0]  pos;
    int        age;
  } ent_t;

  ent_t           m_rs[RS_SIZE];
  bit             m_en;
  bit             m_full;
  bit             m_issued;
  logic [W-1:0]   exp_q[$];

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < RS_SIZE; i++) if (m_rs[i].v) n++;
    return n;
  endfunction

  // Oldest-first: greatest age, lowest index on a (saturated) tie.
  function automatic int m_pick();
    int sel = -1;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m_rs[i].v && m_rs[i].lr && m_rs[i].rr) begin
`ifdef RS_OLDEST_FIRST_EN
        if (sel < 0 || m_rs[i].age > m_rs[sel].age) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    return sel;
  endfunction

  task automatic model_step();
    int slot;
    int sel;
    m_issued = 1'b0;
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        m_rs[i].v   = 1'b0;
        m_rs[i].age = 0;
      end
      m_en = 1'b0;
    end else if (bus.rdy) begin
      if (bus.clear_flag_in) begin
        for (int i = 0; i < RS_SIZE; i++) m_rs[i].v = 1'b0;
        m_en = 1'b0;
      end else if (bus.update_stat) begin
        bit was_full = (m_count() == RS_SIZE);
        m_en = 1'b0;
        if (bus.cdb_enable_in) begin
          for (int i = 0; i < RS_SIZE; i++) begin
            if (m_rs[i].v && !m_rs[i].lr && m_rs[i].ltag == bus.cdb_pos_in_iq_in) begin
              m_rs[i].lr = 1'b1; m_rs[i].lval = bus.cdb_result_in;
            end
            if (m_rs[i].v && !m_rs[i].rr && m_rs[i].rtag == bus.cdb_pos_in_iq_in) begin
              m_rs[i].rr = 1'b1; m_rs[i].rval = bus.cdb_result_in;
            end
          end
        end
        if (bus.dsp_enable_in && !was_full) begin
          slot = -1;
          for (int i = 0; i < RS_SIZE; i++) if (!m_rs[i].v && slot < 0) slot = i;
          for (int i = 0; i < RS_SIZE; i++)
            if (m_rs[i].v && m_rs[i].age < RS_SIZE - 1) m_rs[i].age++;
          m_rs[slot].v    = 1'b1;
          m_rs[slot].age  = 0;
          m_rs[slot].code = bus.dsp_calc_code_in;
          m_rs[slot].pos  = bus.dsp_pos_in_iq_in;
          m_rs[slot].ltag = bus.dsp_lhs_in[3:0];
          m_rs[slot].rtag = bus.dsp_rhs_in[3:0];
          m_rs[slot].lr   = bus.dsp_lhs_ready_in;
          m_rs[slot].lval = bus.dsp_lhs_in;
          m_rs[slot].rr   = bus.dsp_rhs_ready_in;
          m_rs[slot].rval = bus.dsp_rhs_in;
          if (bus.cdb_enable_in && !bus.dsp_lhs_ready_in && bus.dsp_lhs_in[3:0] == bus.cdb_pos_in_iq_in) begin
            m_rs[slot].lr = 1'b1; m_rs[slot].lval = bus.cdb_result_in;
          end
          if (bus.cdb_enable_in && !bus.dsp_rhs_ready_in && bus.dsp_rhs_in[3:0] == bus.cdb_pos_in_iq_in) begin
            m_rs[slot].rr = 1'b1; m_rs[slot].rval = bus.cdb_result_in;
          end
        end
      end else begin
        sel = m_pick();
        if (!bus.alu_full_in && sel >= 0) begin
          exp_q.push_back({m_rs[sel].code, m_rs[sel].lval, m_rs[sel].rval, m_rs[sel].pos});
          m_rs[sel].v = 1'b0;
          m_en        = 1'b1;
          m_issued    = 1'b1;
        end else begin
          m_en = 1'b0;
        end
      end
    end
    m_full = (m_count() == RS_SIZE);
  endtask

  always @(posedge clk) model_step();

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_pkt;
    logic [W-1:0] act_pkt;
    n_chk++;
    if (bus.full_out !== m_full) begin
      n_fail++;
      $display("FAIL full_out @%0t: got %b expected %b", $time, bus.full_out, m_full);
    end
    n_chk++;
    if (bus.alu_calc_enable_out !== m_en) begin
      n_fail++;
      $display("FAIL issue_valid @%0t: got %b expected %b", $time, bus.alu_calc_enable_out, m_en);
    end
    if (m_issued && exp_q.size() > 0) begin
      exp_pkt = exp_q.pop_front();
      act_pkt = {bus.alu_calc_code_out, bus.alu_lhs_out, bus.alu_rhs_out, bus.alu_pos_in_iq_out};
      n_chk++;
      if (act_pkt !== exp_pkt) begin
        n_fail++;
        $display("FAIL issue_pkt @%0t: got %h expected %h", $time, act_pkt, exp_pkt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.dsp_enable_in    = 1'b0;
    bus.cdb_enable_in    = 1'b0;
    bus.clear_flag_in    = 1'b0;
    bus.dsp_calc_code_in = '0;
    bus.dsp_lhs_ready_in = 1'b1;
    bus.dsp_lhs_in       = '0;
    bus.dsp_rhs_ready_in = 1'b1;
    bus.dsp_rhs_in       = '0;
    bus.dsp_pos_in_iq_in = '0;
    bus.cdb_pos_in_iq_in = '0;
    bus.cdb_result_in    = '0;
  endtask

  // Called at a negedge: one edge in the given phase, returns at the next negedge.
  task automatic step(input logic upd);
    bus.update_stat = upd;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic dispatch(input logic [3:0] code, input logic lr, input logic [31:0] lhs,
                          input logic rr, input logic [31:0] rhs, input logic [3:0] pos);
    bus.dsp_enable_in    = 1'b1;
    bus.dsp_calc_code_in = code;
    bus.dsp_lhs_ready_in = lr;
    bus.dsp_lhs_in       = lhs;
    bus.dsp_rhs_ready_in = rr;
    bus.dsp_rhs_in       = rhs;
    bus.dsp_pos_in_iq_in = pos;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_enable_in    = 1'b1;
    bus.cdb_pos_in_iq_in = tag;
    bus.cdb_result_in    = val;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  issues;
    logic phase;
    bus.rdy         = 1'b1;
    bus.update_stat = 1'b1;
    bus.alu_full_in = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_full", 32'(bus.full_out), 0);
    chk("reset_issue_valid", 32'(bus.alu_calc_enable_out), 0);
    chk("reset_lhs_out", bus.alu_lhs_out, 0);
    rst = 1'b1;

    // Both operands ready: issue on the very next edge.
    dispatch(4'd0, 1'b1, 32'd5, 1'b1, 32'd7, 4'd3);
    step(1'b1);
    step(1'b0);
    chk("basic_valid", 32'(bus.alu_calc_enable_out), 1);
    chk("basic_lhs", bus.alu_lhs_out, 5);
    chk("basic_rhs", bus.alu_rhs_out, 7);
    chk("basic_pos", 32'(bus.alu_pos_in_iq_out), 3);
    chk("basic_code", 32'(bus.alu_calc_code_out), 0);
    chk("basic_full", 32'(bus.full_out), 0);
    step(1'b1);
    chk("pulse_one_cycle", 32'(bus.alu_calc_enable_out), 0);

    // Waiting lhs woken by a later broadcast.
    dispatch(4'd1, 1'b0, 32'd2, 1'b1, 32'd1, 4'd5);
    step(1'b1);
    step(1'b0);
    chk("wait_no_issue", 32'(bus.alu_calc_enable_out), 0);
    cdb(4'd2, 32'h10);
    step(1'b1);
    step(1'b0);
    chk("wake_valid", 32'(bus.alu_calc_enable_out), 1);
    chk("wake_lhs", bus.alu_lhs_out, 32'h10);
    chk("wake_pos", 32'(bus.alu_pos_in_iq_out), 5);
    step(1'b1);

    // Broadcast in the same cycle as the dispatch.
    dispatch(4'd2, 1'b0, 32'd4, 1'b1, 32'd3, 4'd6);
    cdb(4'd4, 32'd9);
    step(1'b1);
    step(1'b0);
    chk("same_cycle_valid", 32'(bus.alu_calc_enable_out), 1);
    chk("same_cycle_lhs", bus.alu_lhs_out, 9);
    step(1'b1);

    // Fill while the ALU is busy, drop a 9th, then drain.
    bus.alu_full_in = 1'b1;
    for (int i = 0; i < RS_SIZE; i++) begin
      dispatch(4'(i), 1'b1, 32'(i), 1'b1, 32'(100 + i), 4'(i));
      step(1'b1);
      step(1'b0);
    end
    chk("fill_full", 32'(bus.full_out), 1);
    chk("fill_no_issue", 32'(bus.alu_calc_enable_out), 0);
    dispatch(4'd9, 1'b1, 32'd99, 1'b1, 32'd99, 4'd9);
    step(1'b1);
    chk("drop_full", 32'(bus.full_out), 1);
    step(1'b0);
    bus.alu_full_in = 1'b0;
    step(1'b1);
    step(1'b0);
    chk("drain_first_valid", 32'(bus.alu_calc_enable_out), 1);
    chk("drain_first_lhs", bus.alu_lhs_out, 0);
    chk("drain_full_falls", 32'(bus.full_out), 0);
    issues = 0;
    for (int i = 0; i < RS_SIZE - 1; i++) begin
      step(1'b1);
      step(1'b0);
      if (bus.alu_calc_enable_out === 1'b1) issues++;
    end
    chk("drain_count", 32'(issues), 7);
    chk("drain_last_lhs", bus.alu_lhs_out, 7);
    step(1'b1);
    step(1'b0);
    chk("ninth_dropped", 32'(bus.alu_calc_enable_out), 0);

    // Flush with pending operands; old tags must not resurrect anything.
    dispatch(4'd3, 1'b0, 32'd6, 1'b1, 32'd1, 4'd1);
    step(1'b1);
    step(1'b0);
    dispatch(4'd4, 1'b1, 32'd1, 1'b0, 32'd7, 4'd2);
    step(1'b1);
    bus.clear_flag_in = 1'b1;
    step(1'b1);
    chk("clear_full", 32'(bus.full_out), 0);
    chk("clear_valid", 32'(bus.alu_calc_enable_out), 0);
    cdb(4'd6, 32'd66);
    step(1'b1);
    cdb(4'd7, 32'd77);
    step(1'b0);
    chk("clear_stale_tag", 32'(bus.alu_calc_enable_out), 0);
    step(1'b1);
    step(1'b0);
    chk("clear_stale_tag2", 32'(bus.alu_calc_enable_out), 0);

    // Issue ordering: A waits, B and C ready, A woken after they go.
    bus.alu_full_in = 1'b1;
    dispatch(4'd5, 1'b0, 32'd8, 1'b1, 32'd1, 4'd1); step(1'b1); step(1'b0);
    dispatch(4'd5, 1'b1, 32'hB, 1'b1, 32'd1, 4'd2); step(1'b1); step(1'b0);
    dispatch(4'd5, 1'b1, 32'hC, 1'b1, 32'd1, 4'd3); step(1'b1); step(1'b0);
    bus.alu_full_in = 1'b0;
    step(1'b1); step(1'b0);
    chk("order_b", bus.alu_lhs_out, 32'hB);
    step(1'b1); step(1'b0);
    chk("order_c", bus.alu_lhs_out, 32'hC);
    cdb(4'd8, 32'hA);
    step(1'b1); step(1'b0);
    chk("order_a", bus.alu_lhs_out, 32'hA);

    // Reused low slot: young D versus older ready F.
    bus.alu_full_in = 1'b1;
    dispatch(4'd6, 1'b1, 32'hE0, 1'b1, 32'd2, 4'd4); step(1'b1); step(1'b0);
    dispatch(4'd6, 1'b1, 32'hF0, 1'b1, 32'd2, 4'd5); step(1'b1); step(1'b0);
    dispatch(4'd6, 1'b1, 32'h60, 1'b1, 32'd2, 4'd6); step(1'b1);
    bus.alu_full_in = 1'b0;
    step(1'b0);
    chk("reuse_first", bus.alu_lhs_out, 32'hE0);
    bus.alu_full_in = 1'b1;
    dispatch(4'd7, 1'b1, 32'hD0, 1'b1, 32'd2, 4'd7); step(1'b1);
    bus.alu_full_in = 1'b0;
    step(1'b0);
`ifdef RS_OLDEST_FIRST_EN
    chk("reuse_oldest", bus.alu_lhs_out, 32'hF0);
`else
    chk("reuse_lowest", bus.alu_lhs_out, 32'hD0);
`endif
    repeat (3) begin
      step(1'b1);
      step(1'b0);
    end

    // Randomized traffic against the model.
    phase = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 399) != 0);
      bus.rdy = (!rst) ? 1'b1 : ($urandom_range(0, 9) != 0);
      bus.clear_flag_in = ($urandom_range(0, 59) == 0);
      bus.alu_full_in   = ($urandom_range(0, 2) == 0);
      bus.dsp_enable_in    = ($urandom_range(0, 1) == 1);
      bus.dsp_calc_code_in = 4'($urandom_range(0, 15));
      bus.dsp_lhs_ready_in = ($urandom_range(0, 2) != 0);
      bus.dsp_lhs_in       = $urandom;
      bus.dsp_rhs_ready_in = ($urandom_range(0, 2) != 0);
      bus.dsp_rhs_in       = $urandom;
      bus.dsp_pos_in_iq_in = 4'($urandom_range(0, 15));
      bus.cdb_enable_in    = ($urandom_range(0, 1) == 1);
      bus.cdb_pos_in_iq_in = 4'($urandom_range(0, 15));
      bus.cdb_result_in    = $urandom;
      if (bus.rdy) phase = ~phase;
      bus.update_stat = ($urandom_range(0, 19) == 0) ? ~phase : phase;
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
